rk4_step_sequencer: RTL and testbench

//  Sequences an n-step RK4 integration of dy/dx = f(x,y) in signed Q16.16 fixed point.

---
 rtl/rk4_step_sequencer.sv | 164 ++++++++++++++++
 tb/tb_rk4_step_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rk4_step_sequencer.sv
// RK4 step sequencer: drives an external f(x,y) evaluator through four stage
// evaluations per step, accumulates k1..k4 and advances X/Y in signed Q16.16.
module rk4_step_sequencer #(
  parameter int               WIDTH     = 32,
  parameter int               FRAC      = 16,
  parameter logic [WIDTH-1:0] ONE_SIXTH = 32'h00002AAB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             sel_in,
  input  logic [WIDTH-1:0] x_o,
  input  logic [WIDTH-1:0] y_o,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] n_iteration,
  output logic             f_req,
  output logic [WIDTH-1:0] f_x,
  output logic [WIDTH-1:0] f_y,
  input  logic             f_ack,
  input  logic [WIDTH-1:0] f_val,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done
);

  localparam int CW = WIDTH - FRAC;

  typedef enum logic [2:0] {IDLE, K1, K2, K3, K4, UPD, FIN} state_t;

  // Evaluator argument pair for the current stage
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } farg_t;

  state_t           state, state_nxt;
  logic             btn_q;
  logic             start;
  logic [WIDTH-1:0] h_r, hh;
  logic [CW-1:0]    n_lat, cnt;
  logic [WIDTH-1:0] k1, k2, k3, k4;
  logic [WIDTH-1:0] s_sum;
  logic             in_stage;
  farg_t            arg;

  // Fraction of the step count is deliberately dropped.
  logic unused_frac;
  assign unused_frac = ^n_iteration[FRAC-1:0];

  // Signed fixed-point multiply: full product, keep the middle WIDTH bits (wraps).
  function automatic logic [WIDTH-1:0] mul(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    return WIDTH'(p >>> FRAC);
  endfunction

  assign hh       = {h_r[WIDTH-1], h_r[WIDTH-1:1]};
  assign start    = (state == IDLE) && btn && !btn_q;
  assign in_stage = (state == K1) || (state == K2) || (state == K3) || (state == K4);
  assign s_sum    = k1 + {k2[WIDTH-2:0], 1'b0} + {k3[WIDTH-2:0], 1'b0} + k4;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, status outputs and stage argument selection
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    arg.x     = X;
    arg.y     = Y;
    case (state)
      IDLE: if (start) state_nxt = (n_iteration[WIDTH-1:FRAC] == '0) ? FIN : K1;
      K1: begin
        busy = 1'b1;
        if (f_req && f_ack) state_nxt = K2;
      end
      K2: begin
        busy  = 1'b1;
        arg.x = X + hh;
        arg.y = Y + mul(hh, k1);
        if (f_req && f_ack) state_nxt = K3;
      end
      K3: begin
        busy  = 1'b1;
        arg.x = X + hh;
        arg.y = Y + mul(hh, k2);
        if (f_req && f_ack) state_nxt = K4;
      end
      K4: begin
        busy  = 1'b1;
        arg.x = X + h_r;
        arg.y = Y + mul(h_r, k3);
        if (f_req && f_ack) state_nxt = UPD;
      end
      UPD: begin
        busy      = 1'b1;
        state_nxt = ((cnt + CW'(1)) < n_lat) ? K1 : FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: start latch, stage handshake / k capture, step update
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
      h_r   <= '0;
      n_lat <= '0;
      cnt   <= '0;
      X     <= '0;
      Y     <= '0;
      f_x   <= '0;
      f_y   <= '0;
      f_req <= 1'b0;
      k1    <= '0;
      k2    <= '0;
      k3    <= '0;
      k4    <= '0;
    end else begin
      btn_q <= btn;
      if (start) begin
        h_r   <= c;
        n_lat <= n_iteration[WIDTH-1:FRAC];
        cnt   <= '0;
        if (sel_in) begin
          X <= x_o;
          Y <= y_o;
        end
      end
      // First stage cycle has f_req low: register args, then raise the request.
      if (in_stage) begin
        if (!f_req) begin
          f_x   <= arg.x;
          f_y   <= arg.y;
          f_req <= 1'b1;
        end else if (f_ack) begin
          f_req <= 1'b0;
          case (state)
            K1:      k1 <= f_val;
            K2:      k2 <= f_val;
            K3:      k3 <= f_val;
            default: k4 <= f_val;
          endcase
        end
      end
      if (state == UPD) begin
        Y   <= Y + mul(mul(h_r, s_sum), ONE_SIXTH);
        X   <= X + h_r;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rk4_step_sequencer.sv
// Scoreboard bench for rk4_step_sequencer: a behavioural RK4 model predicts the
// evaluator argument stream and the final X/Y; a monitor plays the evaluator.
module tb_rk4_step_sequencer;

  localparam logic [31:0] SIXTH = 32'h00002AAB;

  logic        clk = 1'b0;
  logic        rst, btn, sel_in, f_ack;
  logic [31:0] x_o, y_o, c, n_iteration, f_val;
  logic        f_req, busy, done;
  logic [31:0] f_x, f_y, X, Y;

  rk4_step_sequencer dut (
    .clk(clk), .rst(rst), .btn(btn), .sel_in(sel_in),
    .x_o(x_o), .y_o(y_o), .c(c), .n_iteration(n_iteration),
    .f_req(f_req), .f_x(f_x), .f_y(f_y), .f_ack(f_ack), .f_val(f_val),
    .X(X), .Y(Y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int mode = 0, dly = 0, hs_cnt = 0;
  logic [31:0] mx = '0, my = '0;
  logic [31:0] q_fx[$], q_fy[$], q_X[$], q_Y[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Q16.16 multiply, truncating and wrapping
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 32'(p >>> 16);
  endfunction

  // The evaluator functions the bench can play
  function automatic logic [31:0] fev(input int m, input logic [31:0] x, input logic [31:0] y);
    case (m)
      0:       return y;
      1:       return 32'h00020000;
      2:       return x - y;
      default: return fmul(x, y) + 32'h00008000;
    endcase
  endfunction

  task automatic push_arg(input logic [31:0] ax, input logic [31:0] ay);
    q_fx.push_back(ax);
    q_fy.push_back(ay);
  endtask

  // Reference RK4 run: predicts every stage argument and the final X/Y
  task automatic model_run(input logic s, input logic [31:0] x0, input logic [31:0] y0,
                           input logic [31:0] h, input logic [31:0] n);
    logic [31:0] hh, k1, k2, k3, k4, sum;
    if (s) begin mx = x0; my = y0; end
    hh = 32'($signed(h) >>> 1);
    for (int i = 0; i < int'(n[31:16]); i++) begin
      push_arg(mx, my);                    k1 = fev(mode, mx, my);
      push_arg(mx + hh, my + fmul(hh, k1)); k2 = fev(mode, mx + hh, my + fmul(hh, k1));
      push_arg(mx + hh, my + fmul(hh, k2)); k3 = fev(mode, mx + hh, my + fmul(hh, k2));
      push_arg(mx + h, my + fmul(h, k3));   k4 = fev(mode, mx + h, my + fmul(h, k3));
      sum = k1 + 2 * k2 + 2 * k3 + k4;
      my  = my + fmul(fmul(h, sum), SIXTH);
      mx  = mx + h;
    end
    q_X.push_back(mx);
    q_Y.push_back(my);
  endtask

  task automatic flush();
    q_fx.delete(); q_fy.delete(); q_X.delete(); q_Y.delete();
  endtask

  // Evaluator + monitor: answers requests after dly wait cycles, checks args
  // against the scoreboard, argument stability, and X/Y on every done pulse.
  initial begin
    logic        prev_req;
    logic [31:0] hold_x, hold_y;
    int          wcnt;
    prev_req = 1'b0; hold_x = '0; hold_y = '0; wcnt = 0;
    f_ack = 1'b0; f_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0; wcnt = 0; f_ack = 1'b0;
      end else begin
        if (f_req) begin
          if (!prev_req) begin
            hs_cnt++;
            hold_x = f_x; hold_y = f_y; wcnt = 0;
            if (q_fx.size() == 0) chk("unexpected_f_req", 32'd1, 32'd0);
            else begin
              chk("f_x_arg", f_x, q_fx.pop_front());
              chk("f_y_arg", f_y, q_fy.pop_front());
            end
          end else begin
            chk("f_x_stable", f_x, hold_x);
            chk("f_y_stable", f_y, hold_y);
          end
          if (wcnt == dly) begin f_ack = 1'b1; f_val = fev(mode, f_x, f_y); end
          else begin f_ack = 1'b0; f_val = $urandom; end
          wcnt++;
        end else begin
          // stray acks with garbage data while idle must be ignored
          f_ack = ($urandom_range(0, 3) == 0);
          f_val = $urandom;
          wcnt  = 0;
        end
        prev_req = f_req;
        if (done) begin
          chk("busy_at_done", busy, 1'b0);
          if (q_X.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            chk("X_final", X, q_X.pop_front());
            chk("Y_final", Y, q_Y.pop_front());
          end
        end
      end
    end
  end

  task automatic start_run(input int m, input int d, input logic s, input logic [31:0] x0,
                           input logic [31:0] y0, input logic [31:0] h, input logic [31:0] n);
    mode = m; dly = d;
    model_run(s, x0, y0, h, n);
    hs_cnt = 0;
    sel_in = s; x_o = x0; y_o = y0; c = h; n_iteration = n;
    btn = 1'b1;
    tick();
  endtask

  // Full run: start, wait (bounded) for done, check latency and handshake count
  task automatic run(input int m, input int d, input logic s, input logic [31:0] x0,
                     input logic [31:0] y0, input logic [31:0] h, input logic [31:0] n,
                     input bit noise);
    int k, nn;
    bit got;
    nn = int'(n[31:16]);
    start_run(m, d, s, x0, y0, h, n);
    if (!noise) btn = 1'b0;
    got = 0;
    k = 1;
    while (k <= 3000) begin
      if (k == 1) chk("busy_after_start", {31'd0, busy}, {31'd0, nn != 0});
      if (done) begin got = 1; break; end
      if (noise) begin
        btn = 1'($urandom); sel_in = 1'($urandom);
        x_o = $urandom; y_o = $urandom; c = $urandom; n_iteration = $urandom;
      end
      tick();
      k++;
    end
    btn = 1'b0;
    // k counts negedges from the start edge; k-1 cycles from busy rise to done
    chk("latency", got ? k : 0, 1 + nn * (9 + 4 * d));
    chk("handshakes", hs_cnt, 4 * nn);
    repeat (3) tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("sb_drained", q_X.size() + q_fx.size(), 32'd0);
    if (!got) flush();
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sel_in = 1'b0;
    x_o = '0; y_o = '0; c = '0; n_iteration = '0;
    repeat (3) tick();
    chk("rst_X", X, 32'd0);
    chk("rst_Y", Y, 32'd0);
    chk("rst_f_x", f_x, 32'd0);
    chk("rst_f_y", f_y, 32'd0);
    chk("rst_f_req", {31'd0, f_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();

    // f=y, one step of h=1 from y=1
    run(0, 0, 1'b1, 32'h0, 32'h10000, 32'h10000, 32'h10000, 0);
    chk("case1_X", X, 32'h00010000);
    // same with 3 evaluator wait cycles per stage
    run(0, 3, 1'b1, 32'h0, 32'h10000, 32'h10000, 32'h10000, 0);
    // constant slope, ten steps
    run(1, 1, 1'b1, 32'h0, 32'h10000, 32'h10000, 32'hA0000, 0);
    chk("case3_X", X, 32'h000A0000);
    chk("case3_Y", Y, 32'h00150028);
    // zero integer step count
    run(0, 0, 1'b1, 32'h12345, 32'h6789, 32'h10000, 32'h0000FFFF, 0);
    chk("n0_X", X, 32'h00012345);
    // btn noise during the run, then continue from current X/Y
    run(0, 2, 1'b1, 32'h0, 32'h10000, 32'h10000, 32'h10000, 1);
    run(0, 0, 1'b0, 32'hDEAD0000, 32'hBEEF0000, 32'h10000, 32'h10000, 0);
    chk("continue_X", X, 32'h00020000);

    // reset while K3 waits on its ack
    begin
      int k;
      start_run(0, 4, 1'b1, 32'h0, 32'h10000, 32'h10000, 32'h10000);
      btn = 1'b0;
      k = 0;
      while (!(hs_cnt == 3 && f_req) && k < 200) begin tick(); k++; end
      chk("reached_K3", {31'd0, f_req}, 32'd1);
      rst = 1'b1;
      tick();
      chk("midrst_f_req", {31'd0, f_req}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_X", X, 32'd0);
      chk("midrst_Y", Y, 32'd0);
      rst = 1'b0;
      flush();
      mx = '0; my = '0;
      tick();
      run(0, 0, 1'b1, 32'h0, 32'h10000, 32'h10000, 32'h10000, 0);
    end

    // randomized runs over all evaluator functions
    for (int i = 0; i < 10; i++) begin
      logic [31:0] rx, ry, rh, rn;
      rx = 32'($urandom_range(0, 32'h40000)) - 32'h20000;
      ry = 32'($urandom_range(0, 32'h40000)) - 32'h20000;
      rh = 32'($urandom_range(0, 32'h20000)) - 32'h8000;
      rn = {16'($urandom_range(0, 4)), 16'($urandom)};
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
          rx, ry, rh, rn, bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
